matvec_loader: RTL
==================

Name: matvec_loader

Overview:
- Upstream fill stage of the matrix-vector MAC array.
- Walks the memory wrapper's Avalon-MM read port and issues one read per 64-bit word:
  - word 0 holds the B vector;
  - words 1..NUM_ROWS hold A rows 0..NUM_ROWS-1.
- Serialises each word into bytes and pushes them into the B FIFO or the matching A FIFO.
- Signals done when every FIFO holds its full row, so the compute controller can start draining.

Parameters:
- DATA_WIDTH, 8, element width in bits.
- NUM_ROWS, 8, number of A rows/FIFOs; also the number of bytes per memory word.
- ADDR_WIDTH, 32, memory word-address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; begins a load when idle.
- mem_address  out  ADDR_WIDTH  word address of the current read.
- mem_read  out  1  Avalon read request.
- mem_readdata  in  NUM_ROWS*DATA_WIDTH  read data.
- mem_readdatavalid  in  1  read data valid.
- mem_waitrequest  in  1  slave stall; a request is accepted when mem_read=1 and mem_waitrequest=0.
- fifo_wdata  out  DATA_WIDTH  shared write data to all FIFOs.
- fifo_wrreq_b  out  1  B FIFO write strobe.
- fifo_wrfull_b  in  1  B FIFO full.
- fifo_wrreq_a  out  NUM_ROWS  A FIFO write strobes, one-hot or zero.
- fifo_wrfull_a  in  NUM_ROWS  A FIFO full flags.
- busy  out  1  high from start acceptance until DONE.
- done  out  1  level; load complete.

Behaviour:
- Reset: all outputs 0, state IDLE, internal word address 0, byte index 0. Asynchronous reset mid-load aborts immediately; no partial state survives.
- IDLE:
  - on start: addr<=0, done<=0, busy<=1, go REQ.
  - start in any other state except DONE is ignored.
- REQ:
  - mem_read=1, mem_address=addr.
  - Address and read are held stable while mem_waitrequest=1.
  - On acceptance, go WAIT; mem_read drops the next cycle.
- WAIT:
  - mem_read=0.
  - On mem_readdatavalid, capture mem_readdata into the word register, byte index<=0, go DRAIN.
  - Only one read is outstanding at any time.
  - mem_readdatavalid in any state other than WAIT is ignored.
- DRAIN:
  - Byte order: byte j = word[DATA_WIDTH*j +: DATA_WIDTH], j=0 first. The first write occurs the cycle after readdatavalid.
  - Target: addr 0 -> B FIFO; addr k (1..NUM_ROWS) -> A FIFO k-1.
  - When the target full flag is 0: assert that wrreq for one cycle with fifo_wdata=byte j, then j++.
  - When the target full flag is 1: wrreq=0, hold j and fifo_wdata, and retry every cycle. No byte is dropped or duplicated.
  - After byte NUM_ROWS-1 is written: if addr==NUM_ROWS go DONE, else addr++ and go REQ.
  - At most one wrreq bit across A and B is high in any cycle.
- DONE:
  - done=1, busy=0, all strobes 0, mem_read=0.
  - A start pulse re-enters the load as from IDLE: done clears, addr<=0.
- Throughput without stalls is one word per (request + memory latency + 1 + NUM_ROWS) cycles. Total writes per load = (NUM_ROWS+1)*NUM_ROWS = 72 at defaults.
- Address arithmetic: addr is ADDR_WIDTH wide but never exceeds NUM_ROWS; no wrap is possible.

Decomposition:
- Package matvec_pkg:
  - DATA_WIDTH, NUM_ROWS, WORD_WIDTH=DATA_WIDTH*NUM_ROWS.
  - Loader state enum {IDLE, REQ, WAIT, DRAIN, DONE}.
  - FIFO target type: B or A index.
- Sub-module word_serializer:
  - Loads a WORD_WIDTH word and emits DATA_WIDTH bytes LSB-first.
  - Valid/ready handshake: ready = ~target_full.
  - Outputs a last flag on the final byte.
- The loader top holds the FSM, address counter and target-select decode.

Test Plan:
- Basic load:
  - Stimulus: memory model with 3-cycle latency and no waitrequest; word0=64'h0807060504030201, word k = {8{k[7:0]}}; start pulse.
  - Response: mem_address sequence 0..8; B FIFO receives 01,02,...,08 in order; A FIFO k-1 receives eight bytes of k; 72 writes total; done=1, busy=0 at the end.
- Waitrequest:
  - Stimulus: mem_waitrequest=1 for 4 cycles on the addr 2 request.
  - Response: mem_read=1 and mem_address=2 held stable all 4 cycles; exactly one accepted read; data still correct.
- Backpressure:
  - Stimulus: fifo_wrfull_a[3]=1 for 5 cycles starting at byte 2 of addr 4.
  - Response: fifo_wrreq_a[3]=0 and fifo_wdata=byte 2 held throughout; writes resume afterwards; the FIFO still receives exactly 8 bytes in order.
- Spurious and overlapping inputs:
  - Stimulus: mem_readdatavalid pulse during DRAIN; start pulse while busy.
  - Response: both ignored; byte stream and address sequence unchanged.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 during DRAIN of addr 5, release, then start.
  - Response: all outputs 0 immediately on reset; the new load begins at addr 0 and completes normally with 72 writes.
- Restart:
  - Stimulus: start pulse while in DONE.
  - Response: done drops the next cycle; mem_address=0 with mem_read=1; the full sequence repeats.

Source files
------------

// File: rtl/matvec_loader_pkg.sv
// -----------------------------------------------------------------------------
// matvec_pkg
// Shared types and default sizes for the matrix-vector loader.
//   DATA_WIDTH  element width in bits
//   NUM_ROWS    number of A rows / A FIFOs, also bytes per memory word
//   ADDR_WIDTH  memory word-address width
//   WORD_WIDTH  width of one memory word (one full row or the B vector)
// -----------------------------------------------------------------------------
package matvec_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int NUM_ROWS   = 8;
  localparam int ADDR_WIDTH = 32;
  localparam int WORD_WIDTH = DATA_WIDTH * NUM_ROWS;

  // Loader sequencing: request a word, wait for its data, drain it into a FIFO.
  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN,
    DONE
  } loader_state_e;

  // Word 0 feeds the B FIFO; every other word feeds one indexed A FIFO.
  typedef enum logic {
    TARGET_B,
    TARGET_A
  } target_kind_e;

  // Index width that stays legal for a single-row configuration.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matvec_loader_if.sv
// -----------------------------------------------------------------------------
// matvec_loader_if
// Bundles the loader's Avalon-MM read port and its FIFO write side.
//   mem_address/mem_read          read request towards the memory wrapper
//   mem_readdata/mem_readdatavalid returned word
//   mem_waitrequest               slave stall
//   fifo_wdata                    byte shared by every FIFO
//   fifo_wrreq_b/fifo_wrfull_b    B FIFO strobe / full flag
//   fifo_wrreq_a/fifo_wrfull_a    A FIFO strobes (one-hot or zero) / full flags
// Modports: master = loader side, slave = memory/FIFO side.
// -----------------------------------------------------------------------------
interface matvec_loader_if #(
  parameter int DATA_WIDTH = matvec_pkg::DATA_WIDTH,
  parameter int NUM_ROWS   = matvec_pkg::NUM_ROWS,
  parameter int ADDR_WIDTH = matvec_pkg::ADDR_WIDTH
);

  logic [ADDR_WIDTH-1:0]          mem_address;
  logic                           mem_read;
  logic [NUM_ROWS*DATA_WIDTH-1:0] mem_readdata;
  logic                           mem_readdatavalid;
  logic                           mem_waitrequest;

  logic [DATA_WIDTH-1:0]          fifo_wdata;
  logic                           fifo_wrreq_b;
  logic                           fifo_wrfull_b;
  logic [NUM_ROWS-1:0]            fifo_wrreq_a;
  logic [NUM_ROWS-1:0]            fifo_wrfull_a;

  modport master (
    output mem_address, mem_read,
    input  mem_readdata, mem_readdatavalid, mem_waitrequest,
    output fifo_wdata, fifo_wrreq_b, fifo_wrreq_a,
    input  fifo_wrfull_b, fifo_wrfull_a
  );

  modport slave (
    input  mem_address, mem_read,
    output mem_readdata, mem_readdatavalid, mem_waitrequest,
    input  fifo_wdata, fifo_wrreq_b, fifo_wrreq_a,
    output fifo_wrfull_b, fifo_wrfull_a
  );

endinterface

// File: rtl/matvec_loader_serializer.sv
// -----------------------------------------------------------------------------
// word_serializer
// Holds one memory word and hands it out one element at a time, LSB first.
//   clk, rst_n  clock, asynchronous active-low reset
//   load        capture word and restart at element 0
//   word        word to capture
//   ready       consumer can take the current element this cycle
//   valid       an element is being offered
//   data        current element (0 when nothing is offered)
//   last        the offered element is the final one of the word
// -----------------------------------------------------------------------------
module word_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_ROWS   = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           load,
  input  logic [DATA_WIDTH*NUM_ROWS-1:0] word,
  input  logic                           ready,
  output logic                           valid,
  output logic [DATA_WIDTH-1:0]          data,
  output logic                           last
);

  import matvec_pkg::*;

  localparam int             IW       = idx_width(NUM_ROWS);
  localparam logic [IW-1:0]  LAST_IDX = IW'(NUM_ROWS - 1);

  logic [DATA_WIDTH*NUM_ROWS-1:0] word_q;
  logic [IW-1:0]                  idx;

  // The index only advances on an accepted element, so a stalled consumer
  // keeps seeing the same element until it takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      idx    <= '0;
      valid  <= 1'b0;
    end else if (load) begin
      word_q <= word;
      idx    <= '0;
      valid  <= 1'b1;
    end else if (valid && ready) begin
      if (idx == LAST_IDX) begin
        valid <= 1'b0;
      end else begin
        idx <= idx + IW'(1);
      end
    end
  end

  assign data = valid ? word_q[idx*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign last = valid && (idx == LAST_IDX);

endmodule

// File: rtl/matvec_loader.sv
// -----------------------------------------------------------------------------
// matvec_loader
// Fill stage of the matrix-vector MAC array. Reads word 0 (B vector) and
// words 1..NUM_ROWS (A rows) from memory, one outstanding read at a time,
// and streams each word byte-by-byte into the B FIFO or the matching A FIFO.
//   clk, rst_n  clock, asynchronous active-low reset
//   start       one-cycle pulse; begins a load from IDLE or DONE
//   bus         Avalon-MM read port and FIFO write side (master modport)
//   busy        load in progress
//   done        every FIFO has received its full row
// -----------------------------------------------------------------------------
module matvec_loader #(
  parameter int DATA_WIDTH = matvec_pkg::DATA_WIDTH,
  parameter int NUM_ROWS   = matvec_pkg::NUM_ROWS,
  parameter int ADDR_WIDTH = matvec_pkg::ADDR_WIDTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  matvec_loader_if.master bus,
  output logic            busy,
  output logic            done
);

  import matvec_pkg::*;

  localparam int                    IW        = idx_width(NUM_ROWS);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_ROWS);

  loader_state_e         state;
  loader_state_e         next_state;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  addr_clear;
  logic                  addr_inc;

  target_kind_e          target_kind;
  logic [IW-1:0]         a_idx;
  logic                  target_full;

  logic                  ser_load;
  logic                  ser_ready;
  logic                  ser_valid;
  logic                  ser_last;
  logic [DATA_WIDTH-1:0] ser_data;
  logic                  fire;

  // State and word address. Reset drops everything, so an aborted load
  // leaves no trace for the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      addr  <= '0;
    end else begin
      state <= next_state;
      if (addr_clear) begin
        addr <= '0;
      end else if (addr_inc) begin
        addr <= addr + ADDR_WIDTH'(1);
      end
    end
  end

  // Next-state decode. start is only honoured from IDLE or DONE, and
  // readdatavalid only in WAIT, which keeps a single read in flight.
  always_comb begin
    next_state = state;
    addr_clear = 1'b0;
    addr_inc   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          next_state = REQ;
          addr_clear = 1'b1;
        end
      end
      REQ: begin
        if (!bus.mem_waitrequest) begin
          next_state = WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_readdatavalid) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (fire && ser_last) begin
          if (addr == LAST_ADDR) begin
            next_state = DONE;
          end else begin
            next_state = REQ;
            addr_inc   = 1'b1;
          end
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Address 0 is the B vector; address k lands in A FIFO k-1. When addr is 0
  // a_idx wraps to all ones, but it is never used in that case.
  assign target_kind = (addr == '0) ? TARGET_B : TARGET_A;
  assign a_idx       = IW'(addr - ADDR_WIDTH'(1));
  assign target_full = (target_kind == TARGET_B) ? bus.fifo_wrfull_b
                                                 : bus.fifo_wrfull_a[a_idx];

  assign ser_load  = (state == WAIT) && bus.mem_readdatavalid;
  assign ser_ready = !target_full;
  assign fire      = (state == DRAIN) && ser_valid && ser_ready;

  word_serializer #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_ROWS   (NUM_ROWS)
  ) u_serializer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (ser_load),
    .word  (bus.mem_readdata),
    .ready (ser_ready),
    .valid (ser_valid),
    .data  (ser_data),
    .last  (ser_last)
  );

  // Only one strobe can ever be high because there is a single target.
  assign bus.fifo_wdata   = ser_data;
  assign bus.fifo_wrreq_b = fire && (target_kind == TARGET_B);
  assign bus.fifo_wrreq_a = (fire && (target_kind == TARGET_A))
                          ? (NUM_ROWS'(1) << a_idx) : '0;

  assign bus.mem_read    = (state == REQ);
  assign bus.mem_address = addr;
  assign busy            = (state == REQ) || (state == WAIT) || (state == DRAIN);
  assign done            = (state == DONE);

endmodule
